spi_regbank_scanner: RTL

- Sits directly downstream of the SPI slave bus block: it consumes the 1024-bit control bus the host writes over SPI and drives the 1024-bit status bus the host reads back.
- A scan FSM walks the control words one per clock and compares each against a shadow copy.
- On any difference it issues one valid/ready write transaction to the fabric, then updates the shadow.
- It also assembles the status bus from an ID word, counters, scan flags and fabric-written status registers.

---
 rtl/spi_regbank_scanner_if.sv | 30 +++
 rtl/spi_regbank_scanner.sv | 134 +++++++++++++
 2 files changed

// File: rtl/spi_regbank_scanner_if.sv
// Bus bundle between the SPI register bank scanner and its surroundings:
// control/status buses toward the SPI slave, write channel and status-register
// port toward the fabric, and the end-of-pass pulse.
interface spi_regbank_scanner_if #(
  parameter int NWORDS = 64,
  parameter int AW     = 6
);
  logic [NWORDS*16-1:0] ctrl_bus;
  logic [NWORDS*16-1:0] status_bus;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [AW-1:0]        wr_addr;
  logic [15:0]          wr_data;
  logic                 sts_we;
  logic [AW-1:0]        sts_addr;
  logic [15:0]          sts_data;
  logic                 scan_done;

  // scanner side
  modport master (
    input  ctrl_bus, wr_ready, sts_we, sts_addr, sts_data,
    output status_bus, wr_valid, wr_addr, wr_data, scan_done
  );

  // environment side (SPI slave, fabric)
  modport slave (
    output ctrl_bus, wr_ready, sts_we, sts_addr, sts_data,
    input  status_bus, wr_valid, wr_addr, wr_data, scan_done
  );
endinterface

// File: rtl/spi_regbank_scanner.sv
// Walks the host control words one per clock, forwards every word that differs
// from its shadow copy to the fabric as a valid/ready write, and assembles the
// host-readable status bus.
//
// state | meaning
// SCAN  | compare ctrl[idx] against shadow[idx]; advance on match
// ISSUE | write of captured word pending; idx frozen until handshake
module spi_regbank_scanner #(
  parameter int          NWORDS   = 64,
  parameter int          AW       = 6,
  parameter logic [15:0] ID_VALUE = 16'h5A17
) (
  input logic clk,
  input logic reset,
  spi_regbank_scanner_if.master bus
);

  typedef enum logic [0:0] {SCAN, ISSUE} state_t;

  state_t state, state_nxt;

  logic [AW-1:0] idx, idx_nxt;
  logic          wr_valid_q, wr_valid_nxt;
  logic [AW-1:0] wr_addr_q, wr_addr_nxt;
  logic [15:0]   wr_data_q, wr_data_nxt;
  logic          scan_done_q, scan_done_nxt;
  logic          shadow_we;
  logic          write_inc;
  logic          advance;
  logic          wrap;

  logic [15:0] shadow [NWORDS];
  logic [15:0] sts_reg [4:NWORDS-1];
  logic [15:0] write_count;
  logic [15:0] scan_count;
  logic [15:0] ctrl_word;
  logic [5:0]  idx6;
  logic [NWORDS*16-1:0] status_q;

  assign ctrl_word = bus.ctrl_bus[idx*16 +: 16];
  assign idx6      = 6'(idx);
  assign wrap      = advance && (idx == AW'(NWORDS - 1));

  assign bus.wr_valid   = wr_valid_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.scan_done  = scan_done_q;
  assign bus.status_bus = status_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= SCAN;
    else       state <= state_nxt;
  end

  // Next-state and write-channel decisions.
  always_comb begin
    state_nxt    = state;
    wr_valid_nxt = wr_valid_q;
    wr_addr_nxt  = wr_addr_q;
    wr_data_nxt  = wr_data_q;
    shadow_we    = 1'b0;
    write_inc    = 1'b0;
    advance      = 1'b0;
    unique case (state)
      SCAN: begin
        if (ctrl_word != shadow[idx]) begin
          wr_addr_nxt  = idx;
          wr_data_nxt  = ctrl_word;
          wr_valid_nxt = 1'b1;
          state_nxt    = ISSUE;
        end else begin
          advance = 1'b1;
        end
      end
      ISSUE: begin
        if (wr_valid_q && bus.wr_ready) begin
          shadow_we    = 1'b1;
          write_inc    = 1'b1;
          wr_valid_nxt = 1'b0;
          advance      = 1'b1;
          state_nxt    = SCAN;
        end
      end
      default: state_nxt = SCAN;
    endcase
    idx_nxt       = advance ? idx + 1'b1 : idx;
    scan_done_nxt = wrap;
  end

  // Scan datapath: index, write channel, shadow copy and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      scan_done_q <= 1'b0;
      write_count <= '0;
      scan_count  <= '0;
      for (int k = 0; k < NWORDS; k++) shadow[k] <= '0;
    end else begin
      idx         <= idx_nxt;
      wr_valid_q  <= wr_valid_nxt;
      wr_addr_q   <= wr_addr_nxt;
      wr_data_q   <= wr_data_nxt;
      scan_done_q <= scan_done_nxt;
      // The captured value goes to the shadow, so a word that moved during a
      // stall still mismatches and is re-sent on a later pass.
      if (shadow_we) shadow[wr_addr_q] <= wr_data_q;
      if (write_inc) write_count <= write_count + 16'd1;
      if (wrap)      scan_count  <= scan_count + 16'd1;
    end
  end

  // Fabric-written status registers; the low four words are owned by the scanner.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 4; k < NWORDS; k++) sts_reg[k] <= '0;
    end else if (bus.sts_we && (bus.sts_addr >= AW'(4))) begin
      sts_reg[bus.sts_addr] <= bus.sts_data;
    end
  end

  // Status bus, re-registered every cycle from the current state.
  always_ff @(posedge clk) begin
    status_q[15:0]  <= ID_VALUE;
    status_q[31:16] <= write_count;
    status_q[47:32] <= scan_count;
    status_q[63:48] <= {2'b00, idx6, 7'b0000000, wr_valid_q};
    for (int k = 4; k < NWORDS; k++) status_q[k*16 +: 16] <= sts_reg[k];
  end

endmodule
